vga_ca_scroller: RTL and testbench

VGA_CA_SCROLLER -- requirements
Module: vga_ca_scroller

---
 rtl/vga_ca_scroller.sv | 160 ++++++++++++++++
 tb/tb_vga_ca_scroller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_ca_scroller.sv
// Scrolling 1-D cellular automaton renderer: each frame shows successive generations as cell rows.
// Optional macro VGA_CA_LFSR_SEED_EN: reseed fills the seed row from a free-running LFSR.
module vga_ca_scroller #(
  parameter int GRID_W   = 160,
  parameter int LOG_CELL = 2,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        display_on,
  input  logic [7:0]  rule_in,
  input  logic        rule_wr,
  input  logic        wrap,
  input  logic        reseed,
  output logic [5:0]  rgb,
  output logic        frame_start,
  output logic [15:0] gen_count
);

  localparam int CELL = 1 << LOG_CELL;
  localparam int PAD  = (H_ACTIVE - GRID_W * CELL) / 2;
  localparam int CW   = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam logic [GRID_W-1:0] SEED1 = {{(GRID_W-1){1'b0}}, 1'b1} << (GRID_W / 2);
  localparam logic [7:0] RULE_RST = 8'd30;

  logic [7:0]        rule_act_q, rule_act_d, rule_pend_q, rule_pend_d, rule_eff;
  logic              wrap_q, wrap_d;
  logic [GRID_W-1:0] row_q, row_d, seed_q, seed_d, row_stepped, reseed_row;
  logic              valid_q, valid_d, rs_pend_q, rs_pend_d;
  logic [15:0]       gen_q, gen_d;
  logic [5:0]        rgb_q, rgb_d;
  logic              fs_q, fs_d;
  logic              fs_now, row_start, row_one, in_grid;
  logic [10:0]       rel, cell_x;
  logic [CW-1:0]     cidx;

`ifdef VGA_CA_LFSR_SEED_EN
  localparam int FW = $clog2(GRID_W + 1);
  logic [15:0]   lfsr_q, lfsr_d;
  logic [FW-1:0] fill_q, fill_d;
`endif

  // Next generation; the extended vector carries the edge neighbours (zero or wrapped).
  function automatic logic [GRID_W-1:0] ca_step(input logic [GRID_W-1:0] r,
                                                input logic [7:0] rule, input logic w);
    logic [GRID_W+1:0] ext;
    logic [GRID_W-1:0] s;
    ext = {w & r[0], r, w & r[GRID_W-1]};
    s = '0;
    for (int j = 0; j < GRID_W; j++) s[j] = rule[{ext[j], ext[j+1], ext[j+2]}];
    return s;
  endfunction

  assign fs_now      = (pix_x == 10'd0) && (pix_y == 10'd0);
  assign row_start   = (pix_x == 10'd0) && ((pix_y & 10'(CELL - 1)) == 10'd0);
  assign row_one     = (pix_y == 10'(CELL));
  assign row_stepped = ca_step(row_q, rule_act_q, wrap_q);

  assign rel     = {1'b0, pix_x} - 11'(PAD);
  assign cell_x  = rel >> LOG_CELL;
  assign cidx    = cell_x[CW-1:0];
  assign in_grid = display_on && ({1'b0, pix_x} >= 11'(PAD)) && (cell_x < 11'(GRID_W))
                   && (pix_y < 10'(V_ACTIVE));

  always_comb begin
    rule_pend_d = rule_wr ? rule_in : rule_pend_q;
    rule_act_d  = rule_act_q;
    rule_eff    = rule_act_q;
    wrap_d      = wrap_q;
    seed_d      = seed_q;
    valid_d     = valid_q;
    gen_d       = gen_q;
    rs_pend_d   = rs_pend_q;
    row_d       = row_q;
`ifdef VGA_CA_LFSR_SEED_EN
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    fill_d     = fill_q;
    reseed_row = {{(GRID_W-1){1'b0}}, lfsr_q[0]};
`else
    reseed_row = SEED1;
`endif
    // Frame start bypasses the freshly latched rule and seed so pixel (0,0) renders correctly.
    if (fs_now) begin
      rule_act_d = rule_pend_q;
      rule_eff   = rule_pend_q;
      wrap_d     = wrap;
      valid_d    = 1'b1;
      rs_pend_d  = 1'b0;
      if (rs_pend_q) begin
        row_d = reseed_row;
        gen_d = '0;
`ifdef VGA_CA_LFSR_SEED_EN
        fill_d = FW'(1);
`endif
      end else begin
        row_d = seed_q;
        if (valid_q) gen_d = gen_q + 16'd1;
      end
    end else if (row_start) begin
      row_d = row_stepped;
      if (row_one && valid_q) seed_d = row_stepped;
    end
`ifdef VGA_CA_LFSR_SEED_EN
    else if (fill_q < FW'(GRID_W)) begin
      row_d[fill_q] = lfsr_q[0];
      fill_d        = fill_q + FW'(1);
    end
`endif
    if (reseed) rs_pend_d = 1'b1;
    rgb_d = '0;
    if ((valid_q || fs_now) && in_grid && row_d[cidx]) rgb_d = rule_eff[6:1];
    fs_d = fs_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rule_act_q  <= RULE_RST;
      rule_pend_q <= RULE_RST;
      wrap_q      <= 1'b0;
      row_q       <= SEED1;
      seed_q      <= SEED1;
      valid_q     <= 1'b0;
      rs_pend_q   <= 1'b0;
      gen_q       <= '0;
      rgb_q       <= '0;
      fs_q        <= 1'b0;
    end else begin
      rule_act_q  <= rule_act_d;
      rule_pend_q <= rule_pend_d;
      wrap_q      <= wrap_d;
      row_q       <= row_d;
      seed_q      <= seed_d;
      valid_q     <= valid_d;
      rs_pend_q   <= rs_pend_d;
      gen_q       <= gen_d;
      rgb_q       <= rgb_d;
      fs_q        <= fs_d;
    end
  end

`ifdef VGA_CA_LFSR_SEED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
      fill_q <= FW'(GRID_W);
    end else begin
      lfsr_q <= lfsr_d;
      fill_q <= fill_d;
    end
  end
`endif

  assign rgb         = rgb_q;
  assign frame_start = fs_q;
  assign gen_count   = gen_q;

endmodule

// File: tb/tb_vga_ca_scroller.sv
// Bench for vga_ca_scroller: frame-level CA model compared every cycle, plus hand-computed pixel literals.
module tb_vga_ca_scroller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pix_x = 10'd1, pix_y = 10'd524;
  logic        display_on = 1'b0;
  logic [7:0]  rule_in = 8'd0;
  logic        rule_wr = 1'b0, wrap = 1'b0, reseed = 1'b0;
  logic [5:0]  rgb;
  logic        frame_start;
  logic [15:0] gen_count;

  vga_ca_scroller #(.GRID_W(160), .LOG_CELL(2), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .display_on(display_on),
    .rule_in(rule_in), .rule_wr(rule_wr), .wrap(wrap), .reseed(reseed),
    .rgb(rgb), .frame_start(frame_start), .gen_count(gen_count));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic        lit;
    logic [5:0]  lv;
    logic [5:0]  rgb;
    logic        fs;
    logic [15:0] gen;
    logic [9:0]  x;
    logic [9:0]  y;
  } exp_t;

  typedef struct {
    int         y;
    int         x;
    logic [5:0] v;
  } lit_t;

  exp_t exp_nxt = '0, exp_cur = '0;
  int n_tests = 0, n_fail = 0;
  lit_t lit_q[$];
  int full_q[$];
  int ev_rule_y = -1, ev_rs_y = -1, ev_rst_y = -1;
  logic [7:0] ev_rule_v = 8'd0;

  // Model state: whole frame of generations computed at each frame start
  logic [159:0] m_rows [0:119];
  logic [159:0] m_seed, single_row;
  logic [7:0]   m_act, m_pend;
  logic         m_wrap, m_valid, m_rs;
  logic [15:0]  m_gen;

  function automatic logic [159:0] ca_next(input logic [159:0] r, input logic [7:0] rule,
                                          input logic w);
    logic [159:0] n;
    logic l, c, rt;
    n = '0;
    for (int j = 0; j < 160; j++) begin
      l  = (j == 0)   ? (w ? r[159] : 1'b0) : r[j-1];
      c  = r[j];
      rt = (j == 159) ? (w ? r[0] : 1'b0) : r[j+1];
      n[j] = rule[{l, c, rt}];
    end
    return n;
  endfunction

  task automatic model_reset();
    m_act = 8'd30; m_pend = 8'd30; m_wrap = 1'b0; m_seed = single_row;
    m_valid = 1'b0; m_rs = 1'b0; m_gen = '0;
  endtask

  task automatic model_frame_start();
    logic [159:0] s;
    if (m_rs) begin
      s = single_row;
      m_gen = '0;
    end else begin
      s = m_seed;
      if (m_valid) m_gen = m_gen + 16'd1;
    end
    m_act = m_pend;
    m_wrap = wrap;
    m_rows[0] = s;
    for (int k = 1; k < 120; k++) m_rows[k] = ca_next(m_rows[k-1], m_act, m_wrap);
    m_seed = m_rows[1];
    m_valid = 1'b1;
    m_rs = 1'b0;
  endtask

  always @(posedge clk) exp_cur <= exp_nxt;

  always @(negedge clk) begin
    if (exp_cur.en) begin
      n_tests++;
      if ({rgb, frame_start, gen_count} !== {exp_cur.rgb, exp_cur.fs, exp_cur.gen}) begin
        n_fail++;
        if (n_fail < 30)
          $display("FAIL pixel y=%0d x=%0d: rgb/fs/gen got %b/%b/%0d want %b/%b/%0d",
                   exp_cur.y, exp_cur.x, rgb, frame_start, gen_count,
                   exp_cur.rgb, exp_cur.fs, exp_cur.gen);
      end
      if (exp_cur.lit) begin
        n_tests++;
        if (rgb !== exp_cur.lv) begin
          n_fail++;
          $display("FAIL literal y=%0d x=%0d: rgb got %b want %b", exp_cur.y, exp_cur.x,
                   rgb, exp_cur.lv);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic cyc(input int x, input int y, input bit de, input bit wr,
                     input logic [7:0] rv, input bit rs);
    exp_t e;
    @(negedge clk);
    pix_x = 10'(x); pix_y = 10'(y); display_on = de;
    rule_wr = wr; rule_in = rv; reseed = rs;
    if (x == 0 && y == 0) model_frame_start();
    if (wr) m_pend = rv;
    if (rs) m_rs = 1'b1;
    e = '0;
    e.en = 1'b1; e.x = 10'(x); e.y = 10'(y);
    e.fs = (x == 0 && y == 0);
    e.gen = m_gen;
    if (m_valid && de && x < 640 && y < 480 && m_rows[y/4][x/4]) e.rgb = m_act[6:1];
    foreach (lit_q[i]) if (lit_q[i].x == x && lit_q[i].y == y) begin
      e.lit = 1'b1;
      e.lv  = lit_q[i].v;
    end
    exp_nxt = e;
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    rule_wr = 1'b0; reseed = 1'b0; pix_x = 10'd1; pix_y = 10'd524; display_on = 1'b0;
    #1;
    check("reset_rgb", 32'(rgb), 32'd0);
    check("reset_frame_start", 32'(frame_start), 32'd0);
    check("reset_gen_count", 32'(gen_count), 32'd0);
    model_reset();
    e = '0;
    e.en = 1'b1;
    exp_nxt = e;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add_lit(input int y, input int x, input logic [5:0] v);
    lit_t l;
    l.y = y; l.x = x; l.v = v;
    lit_q.push_back(l);
  endtask

  task automatic run_frame();
    for (int y = 0; y < 525; y++) begin
      bit full;
      int n;
      full = 1'b0;
      foreach (full_q[i]) if (full_q[i] == y) full = 1'b1;
      n = full ? 644 : 1;
      for (int x = 0; x < n; x++) begin
        if (y == ev_rst_y && x == 320) do_reset();
        cyc(x, y, (x < 640) && (y < 480), (y == ev_rule_y) && (x == 0), ev_rule_v,
            (y == ev_rs_y) && (x == 0));
      end
    end
    full_q.delete();
    lit_q.delete();
    ev_rule_y = -1; ev_rs_y = -1; ev_rst_y = -1;
  endtask

  initial begin
    single_row = '0;
    single_row[80] = 1'b1;
    model_reset();
    do_reset();

    // Rule 30 from the single seed; rule 90 written mid-frame; reseed requested
    full_q = '{0, 4, 5, 200, 204, 300};
    add_lit(0, 320, 6'b001111); add_lit(0, 316, 6'b000000); add_lit(0, 324, 6'b000000);
    add_lit(4, 316, 6'b001111); add_lit(4, 320, 6'b001111); add_lit(4, 324, 6'b001111);
    add_lit(4, 312, 6'b000000); add_lit(4, 328, 6'b000000); add_lit(5, 317, 6'b001111);
    ev_rule_y = 200; ev_rule_v = 8'd90; ev_rs_y = 300;
    run_frame();
    check("gen_p1_f0", 32'(gen_count), 32'd0);
    full_q = '{0, 4};
    add_lit(0, 320, 6'b101101); add_lit(0, 316, 6'b000000);
    add_lit(4, 316, 6'b101101); add_lit(4, 320, 6'b000000); add_lit(4, 324, 6'b101101);
    run_frame();
    check("gen_p1_f1", 32'(gen_count), 32'd0);

    // Scrolling over several frames, then reseed in frame 5
    do_reset();
    full_q = '{4};
    run_frame();
    full_q = '{4};
    run_frame();
    check("gen_p2_f1", 32'(gen_count), 32'd1);
    full_q = '{0};
    add_lit(0, 308, 6'b000000); add_lit(0, 312, 6'b001111); add_lit(0, 316, 6'b001111);
    add_lit(0, 320, 6'b000000); add_lit(0, 324, 6'b000000); add_lit(0, 328, 6'b001111);
    run_frame();
    check("gen_p2_f2", 32'(gen_count), 32'd2);
    run_frame();
    run_frame();
    ev_rs_y = 100; full_q = '{100};
    run_frame();
    check("gen_p2_f5", 32'(gen_count), 32'd5);
    full_q = '{0};
    add_lit(0, 320, 6'b001111); add_lit(0, 316, 6'b000000); add_lit(0, 324, 6'b000000);
    run_frame();
    check("gen_p2_f6", 32'(gen_count), 32'd0);

    // Rule 2 with toroidal edges, then with zero edges
    do_reset();
    wrap = 1'b1;
    cyc(1, 524, 1'b0, 1'b1, 8'd2, 1'b0);
    full_q = '{320, 324};
    add_lit(320, 0, 6'b000001); add_lit(320, 4, 6'b000000);
    add_lit(324, 636, 6'b000001); add_lit(324, 0, 6'b000000);
    run_frame();
    do_reset();
    wrap = 1'b0;
    cyc(1, 524, 1'b0, 1'b1, 8'd2, 1'b0);
    full_q = '{320, 324};
    add_lit(320, 0, 6'b000001); add_lit(324, 636, 6'b000000);
    run_frame();

    // Reset asserted mid-frame, then a clean frame from the reset seed
    do_reset();
    full_q = '{0, 300};
    add_lit(0, 320, 6'b001111);
    ev_rst_y = 300;
    run_frame();
    full_q = '{0, 4, 5};
    add_lit(0, 320, 6'b001111); add_lit(0, 316, 6'b000000);
    add_lit(4, 316, 6'b001111); add_lit(4, 320, 6'b001111); add_lit(4, 324, 6'b001111);
    add_lit(4, 328, 6'b000000);
    run_frame();
    check("gen_p4_f1", 32'(gen_count), 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
